// File: rtl/mfp_srec_ahb_write_coalescer_pkg.sv
// Shared AHB-Lite codes, buffered-entry layout and the mask splitter used by
// the SREC write coalescer.
package mfp_srec_ahb_write_coalescer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic {
        ST_IDLE,
        ST_ADDR
    } issue_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    typedef struct packed {
        logic [2:0] size;
        logic [1:0] offset;
        logic [3:0] xfer;
    } split_t;

    // Next transfer for the remaining byte mask: full word, else the lowest
    // set offset as a halfword when aligned and paired, otherwise a byte.
    function automatic split_t split_mask(input logic [3:0] m);
        split_t s;
        s.size   = HSIZE_BYTE;
        s.offset = 2'd0;
        s.xfer   = 4'b0000;
        if (m == 4'b1111) begin
            s.size = HSIZE_WORD;
            s.xfer = 4'b1111;
        end else if (m[0]) begin
            if (m[1]) begin
                s.size = HSIZE_HALF;
                s.xfer = 4'b0011;
            end else begin
                s.xfer = 4'b0001;
            end
        end else if (m[1]) begin
            s.offset = 2'd1;
            s.xfer   = 4'b0010;
        end else if (m[2]) begin
            s.offset = 2'd2;
            if (m[3]) begin
                s.size = HSIZE_HALF;
                s.xfer = 4'b1100;
            end else begin
                s.xfer = 4'b0100;
            end
        end else if (m[3]) begin
            s.offset = 2'd3;
            s.xfer   = 4'b1000;
        end
        return s;
    endfunction

endpackage

// File: rtl/mfp_srec_ahb_write_coalescer_if.sv
// AHB-Lite master bus bundle between the coalescer and the matrix.
interface mfp_srec_ahb_write_coalescer_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HREADY
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output HREADY
    );
endinterface

// File: rtl/mfp_srec_ahb_write_coalescer_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module mfp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/mfp_srec_ahb_write_coalescer.sv
// Coalesces SREC byte writes into aligned word/halfword/byte AHB-Lite writes,
// buffering them in a FIFO and honouring HREADY wait states.
//   state   | meaning
//   ST_IDLE | no address phase driven, issuer holds no entry
//   ST_ADDR | NONSEQ address phase for the current split of the held entry
module mfp_srec_ahb_write_coalescer
    import mfp_srec_ahb_write_coalescer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        big_endian,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    input  logic        flush,
    mfp_srec_ahb_write_coalescer_if.master ahb,
    output logic        busy,
    output logic        overflow
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [29:0]      acc_addr;
    logic [31:0]      acc_data;
    logic [3:0]       acc_mask;
    logic [CNT_W-1:0] idle_cnt;

    logic [1:0] wr_off;
    logic [1:0] wr_lane;
    logic       conflict;
    logic       push_req;
    logic       fresh;
    entry_t     push_entry;

    assign wr_off     = write_address[1:0];
    assign wr_lane    = big_endian ? (2'd3 - wr_off) : wr_off;
    assign conflict   = write_enable && (acc_mask != 4'b0000)
                        && ((write_address[31:2] != acc_addr) || acc_mask[wr_off]);
    assign push_req   = (acc_mask != 4'b0000)
                        && ((acc_mask == 4'b1111) || conflict || flush
                            || (!write_enable && (idle_cnt == CNT_W'(TIMEOUT_CYCLES))));
    assign fresh      = push_req || (acc_mask == 4'b0000);
    assign push_entry = '{addr: acc_addr, data: acc_data, mask: acc_mask};

    // A byte arriving alongside any push starts a fresh, zero-filled word.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            acc_addr <= '0;
            acc_data <= '0;
            acc_mask <= '0;
            idle_cnt <= '0;
        end else if (write_enable) begin
            acc_addr <= write_address[31:2];
            idle_cnt <= '0;
            if (fresh) begin
                acc_data <= 32'(write_byte) << {wr_lane, 3'b000};
                acc_mask <= 4'b0001 << wr_off;
            end else begin
                acc_data[{wr_lane, 3'b000} +: 8] <= write_byte;
                acc_mask[wr_off]                 <= 1'b1;
            end
        end else if (push_req) begin
            acc_mask <= '0;
            idle_cnt <= '0;
        end else if (acc_mask != 4'b0000) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    issue_state_t state;
    issue_state_t state_next;
    entry_t       cur;
    split_t       sp;
    entry_t       fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic         accept;
    logic         last;
    logic         free;
    logic         load;
    logic [31:0]  hwdata;
    logic         data_active;
    logic         hwrite;

    assign sp     = split_mask(cur.mask);
    assign accept = (state == ST_ADDR) && ahb.HREADY;
    assign last   = ((cur.mask & ~sp.xfer) == 4'b0000);
    assign free   = (state == ST_IDLE) || (accept && last);

    // The issuer holds one entry outside the FIFO; with an empty FIFO a
    // fresh push bypasses it straight into the issuer.
    assign load      = free && (!fifo_empty || push_req);
    assign fifo_pop  = free && !fifo_empty;
    assign fifo_push = push_req && !(free && fifo_empty);

    mfp_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (accept && last) begin
                    state_next = load ? ST_ADDR : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cur         <= '0;
            hwdata      <= '0;
            data_active <= 1'b0;
            overflow    <= 1'b0;
            hwrite      <= 1'b0;
        end else begin
            hwrite <= 1'b1;
            if (load) begin
                cur <= fifo_empty ? push_entry : fifo_head;
            end else if (accept) begin
                cur.mask <= cur.mask & ~sp.xfer;
            end
            if (accept) begin
                hwdata      <= cur.data;
                data_active <= 1'b1;
            end else if (ahb.HREADY) begin
                data_active <= 1'b0;
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign ahb.HADDR     = {cur.addr, sp.offset};
    assign ahb.HSIZE     = sp.size;
    assign ahb.HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.HWDATA    = hwdata;
    assign ahb.HWRITE    = hwrite;
    assign ahb.HBURST    = HBURST_SINGLE;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HPROT     = HPROT_DEFAULT;

    assign busy = (acc_mask != 4'b0000) || !fifo_empty || (state == ST_ADDR) || data_active;
endmodule

// File: tb/tb_mfp_srec_ahb_write_coalescer.sv
// Directed bench for the SREC AHB-Lite write coalescer: vector table plus
// hand-written latency, timeout, wait-state and overflow sequences.
module tb_mfp_srec_ahb_write_coalescer;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        big_endian = 1'b0;
    logic [31:0] write_address = '0;
    logic [7:0]  write_byte = '0;
    logic        write_enable = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        overflow;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    mfp_srec_ahb_write_coalescer_if bus();

    mfp_srec_ahb_write_coalescer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK          (clk),
        .HRESET        (rst),
        .big_endian    (big_endian),
        .write_address (write_address),
        .write_byte    (write_byte),
        .write_enable  (write_enable),
        .flush         (flush),
        .ahb           (bus),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        wr;
        int          acyc;
        int          dcyc;
    } obs_t;

    obs_t obs_q[$];
    obs_t pend;
    logic dp_pend = 1'b0;

    // Bus monitor: an address phase accepted with HREADY opens a data phase
    // whose HWDATA is taken when HREADY next completes it.
    always @(negedge clk) begin
        if (rst) begin
            dp_pend = 1'b0;
        end else begin
            if (dp_pend && bus.HREADY) begin
                pend.data = bus.HWDATA;
                pend.dcyc = cyc;
                obs_q.push_back(pend);
                dp_pend = 1'b0;
            end
            if (bus.HTRANS == 2'b10 && bus.HREADY) begin
                pend.addr = bus.HADDR;
                pend.size = bus.HSIZE;
                pend.wr   = bus.HWRITE;
                pend.acyc = cyc;
                dp_pend   = 1'b1;
            end
        end
    end

    typedef struct {
        logic        be;
        int          nw;
        logic [31:0] wa [4];
        logic [7:0]  wb [4];
        logic        fl;
        int          nx;
        logic [31:0] xa [2];
        logic [2:0]  xs [2];
        logic [31:0] xd [2];
    } vec_t;

    localparam int NV = 9;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] b);
        step();
        write_address = a;
        write_byte    = b;
        write_enable  = 1'b1;
        flush         = 1'b0;
    endtask

    task automatic do_flush();
        step();
        write_enable = 1'b0;
        flush        = 1'b1;
    endtask

    task automatic idle();
        step();
        write_enable = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while ((obs_q.size() < n || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_busy", {31'b0, busy}, 32'h0);
        chk("xfer_count", obs_q.size(), n);
    endtask

    task automatic chk_obs(input int idx, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d);
        chk("xfer_present", 32'(obs_q.size() > idx), 32'h1);
        if (idx < obs_q.size()) begin
            chk("haddr", obs_q[idx].addr, a);
            chk("hsize", {29'b0, obs_q[idx].size}, {29'b0, s});
            chk("hwdata", obs_q[idx].data, d);
            chk("hwrite", {31'b0, obs_q[idx].wr}, 32'h1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int f;
        int w;

        v[0] = '{1'b0, 4, '{32'h100, 32'h101, 32'h102, 32'h103}, '{8'h11, 8'h22, 8'h33, 8'h44},
                 1'b0, 1, '{32'h100, 32'h0}, '{3'd2, 3'd0}, '{32'h44332211, 32'h0}};
        v[1] = '{1'b1, 4, '{32'h100, 32'h101, 32'h102, 32'h103}, '{8'h11, 8'h22, 8'h33, 8'h44},
                 1'b0, 1, '{32'h100, 32'h0}, '{3'd2, 3'd0}, '{32'h11223344, 32'h0}};
        v[2] = '{1'b0, 3, '{32'h200, 32'h201, 32'h203, 32'h0}, '{8'hA1, 8'hA2, 8'hA4, 8'h0},
                 1'b1, 2, '{32'h200, 32'h203}, '{3'd1, 3'd0}, '{32'hA400A2A1, 32'hA400A2A1}};
        v[3] = '{1'b0, 1, '{32'h402, 32'h0, 32'h0, 32'h0}, '{8'h5C, 8'h0, 8'h0, 8'h0},
                 1'b1, 1, '{32'h402, 32'h0}, '{3'd0, 3'd0}, '{32'h005C0000, 32'h0}};
        v[4] = '{1'b0, 2, '{32'h500, 32'h504, 32'h0, 32'h0}, '{8'h01, 8'h02, 8'h0, 8'h0},
                 1'b1, 2, '{32'h500, 32'h504}, '{3'd0, 3'd0}, '{32'h00000001, 32'h00000002}};
        v[5] = '{1'b0, 2, '{32'h600, 32'h600, 32'h0, 32'h0}, '{8'hAA, 8'hBB, 8'h0, 8'h0},
                 1'b1, 2, '{32'h600, 32'h600}, '{3'd0, 3'd0}, '{32'h000000AA, 32'h000000BB}};
        v[6] = '{1'b1, 2, '{32'h70A, 32'h70B, 32'h0, 32'h0}, '{8'hC1, 8'hC2, 8'h0, 8'h0},
                 1'b1, 1, '{32'h70A, 32'h0}, '{3'd1, 3'd0}, '{32'h0000C1C2, 32'h0}};
        v[7] = '{1'b0, 2, '{32'h801, 32'h802, 32'h0, 32'h0}, '{8'hD1, 8'hD2, 8'h0, 8'h0},
                 1'b1, 2, '{32'h801, 32'h802}, '{3'd0, 3'd0}, '{32'h00D2D100, 32'h00D2D100}};
        v[8] = '{1'b1, 4, '{32'h903, 32'h902, 32'h901, 32'h900}, '{8'h01, 8'h02, 8'h03, 8'h04},
                 1'b0, 1, '{32'h900, 32'h0}, '{3'd2, 3'd0}, '{32'h04030201, 32'h0}};

        bus.HREADY = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_htrans", {30'b0, bus.HTRANS}, 32'h0);
        chk("rst_hsize", {29'b0, bus.HSIZE}, 32'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_hwrite", {31'b0, bus.HWRITE}, 32'h0);
        chk("rst_hburst", {29'b0, bus.HBURST}, 32'h0);
        chk("rst_hmastlock", {31'b0, bus.HMASTLOCK}, 32'h0);
        chk("rst_hprot", {28'b0, bus.HPROT}, 32'h3);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_overflow", {31'b0, overflow}, 32'h0);
        step();
        rst = 1'b0;
        repeat (2) step();

        for (int i = 0; i < NV; i++) begin
            obs_q.delete();
            big_endian = v[i].be;
            for (int k = 0; k < v[i].nw; k++) wr(v[i].wa[k], v[i].wb[k]);
            if (v[i].fl) do_flush();
            idle();
            wait_done(v[i].nx);
            for (int k = 0; k < v[i].nx; k++) chk_obs(k, v[i].xa[k], v[i].xs[k], v[i].xd[k]);
        end

        // Full-word latency and busy fall.
        obs_q.delete();
        big_endian = 1'b0;
        wr(32'h1000, 8'h5A);
        wr(32'h1001, 8'h6B);
        wr(32'h1002, 8'h7C);
        wr(32'h1003, 8'h8D);
        c = cyc;
        idle();
        step();
        step();
        @(negedge clk);
        chk("lat_busy_data_phase", {31'b0, busy}, 32'h1);
        step();
        @(negedge clk);
        chk("lat_busy_fall", {31'b0, busy}, 32'h0);
        chk_obs(0, 32'h1000, 3'd2, 32'h8D7C6B5A);
        if (obs_q.size() > 0) begin
            chk("lat_addr_cycle", obs_q[0].acyc, c + 2);
            chk("lat_data_cycle", obs_q[0].dcyc, c + 3);
        end
        repeat (2) step();

        // Idle timeout flush of a single byte.
        obs_q.delete();
        wr(32'h305, 8'hAA);
        w = cyc;
        idle();
        wait_done(1);
        if (obs_q.size() > 0) begin
            chk("to_addr_cycle", obs_q[0].acyc, w + 2 + TO);
            chk("to_haddr", obs_q[0].addr, 32'h305);
            chk("to_hsize", {29'b0, obs_q[0].size}, 32'h0);
            chk("to_lane", {24'b0, obs_q[0].data[15:8]}, 32'hAA);
        end

        // Wait states across back-to-back split transfers.
        obs_q.delete();
        wr(32'hB00, 8'hE1);
        wr(32'hB01, 8'hE2);
        wr(32'hB03, 8'hE4);
        do_flush();
        f = cyc;
        idle();
        step();
        bus.HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ws_haddr", bus.HADDR, 32'hB03);
            chk("ws_htrans", {30'b0, bus.HTRANS}, 32'h2);
            chk("ws_hsize", {29'b0, bus.HSIZE}, 32'h0);
            chk("ws_hwdata", bus.HWDATA, 32'hE400E2E1);
            step();
        end
        bus.HREADY = 1'b1;
        wait_done(2);
        chk_obs(0, 32'hB00, 3'd1, 32'hE400E2E1);
        chk_obs(1, 32'hB03, 3'd0, 32'hE400E2E1);
        if (obs_q.size() > 1) begin
            chk("ws_first_addr_cycle", obs_q[0].acyc, f + 1);
            chk("ws_second_addr_cycle", obs_q[1].acyc, f + 5);
            chk("ws_second_data_cycle", obs_q[1].dcyc, f + 6);
        end

        // Overflow: one entry in the issuer, DEPTH in the FIFO, the rest dropped.
        obs_q.delete();
        chk("ovf_before", {31'b0, overflow}, 32'h0);
        step();
        bus.HREADY = 1'b0;
        for (int n = 0; n < DEPTH + 2; n++) begin
            for (int b = 0; b < 4; b++) wr(32'hC00 + 32'(4 * n + b), 8'(n + 1));
        end
        idle();
        step();
        @(negedge clk);
        chk("ovf_set", {31'b0, overflow}, 32'h1);
        chk("ovf_none_issued", obs_q.size(), 0);
        step();
        bus.HREADY = 1'b1;
        wait_done(DEPTH + 1);
        for (int n = 0; n < DEPTH + 1; n++) begin
            chk_obs(n, 32'hC00 + 32'(4 * n), 3'd2, {4{8'(n + 1)}});
        end
        chk("ovf_sticky", {31'b0, overflow}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mfp_srec_ahb_write_coalescer.md
# mfp_srec_ahb_write_coalescer

Parametrised successor to the SREC-parser-to-AHB-Lite loader bridge: accepts the parser's byte-write stream, coalesces bytes that share an aligned word into single word, halfword or byte writes, buffers them in a FIFO and issues them as an AHB-Lite master. Unlike the single-byte bridge it honours HREADY, supports wait-stated slaves such as SDRAM, and reports a `busy` flag. The loader wrapper holds the core in reset with `in_progress | busy` so that no buffered write is lost.

## Interface
- `FIFO_DEPTH`, default 4: buffered coalesced words; power of two, ≥2.
- `TIMEOUT_CYCLES`, default 255: idle cycles before a partial word is flushed; ≥1.
- `HCLK` in 1: clock.
- `HRESET` in 1: reset, asynchronous and active-high.
- `big_endian` in 1: lane mapping select; static while `busy`.
- `write_address` in 32: byte address from the SREC parser.
- `write_byte` in 8: byte data.
- `write_enable` in 1: one-cycle byte strobe; no backpressure is available.
- `flush` in 1: one-cycle pulse that pushes the partial word immediately (parser end of record).
- `HREADY` in 1: AHB-Lite ready from the matrix.
- `HADDR` out 32, `HBURST` out 3, `HMASTLOCK` out 1, `HPROT` out 4, `HSIZE` out 3, `HTRANS` out 2, `HWDATA` out 32, `HWRITE` out 1: AHB-Lite master outputs.
- `busy` out 1: high while the accumulator, the FIFO or the AHB pipe is non-empty.
- `overflow` out 1: sticky error flag, cleared only by reset.

## Operation
- **Accumulator** holds `acc_addr[31:2]`, `acc_data[31:0]`, `acc_mask[3:0]` and an idle counter.
- **Mask indexing:** `acc_mask` is indexed by address offset `a = write_address[1:0]`.
- **Data lane:** `a` when little-endian, `3-a` when big-endian. Lane k occupies bits `[8k+7:8k]`.
- **Byte arrival, merge:** if `mask==0`, or if the word address matches and bit `a` is clear, the byte merges into the accumulator and the idle counter is cleared.
- **Byte arrival, conflict:** on a different word, or a repeated offset, the current accumulator is pushed and the new byte starts a fresh accumulator.
- **Push triggers:**
  - `mask==4'b1111`;
  - conflict;
  - `flush` with `mask!=0`;
  - idle counter reaching `TIMEOUT_CYCLES` with `mask!=0`.
- **Full word plus new byte in the same cycle:** the full word is pushed and the byte starts a new word.
- **Push with FIFO full:** the pushed word is discarded and `overflow` is set. The new byte is still accepted.
- **Issuer:** pops the FIFO head and splits its mask into transfers:
  - `1111` → one word write (`HSIZE=3'b010`).
  - Otherwise, repeatedly take the lowest set offset i. If i is even and bit i+1 is set, issue a halfword (`HSIZE=3'b001`) at offset i; else issue a byte (`HSIZE=3'b000`). Clear the issued bits.
  - At most 2 transfers result per entry.
- **Issuer FSM:** `IDLE` → `ADDR` when the FIFO is non-empty.
  - In `ADDR`, the address phase is driven. On HREADY it advances to the next split, the next entry, or `IDLE`.
  - A separate data-phase register drives `HWDATA` one cycle after each accepted address phase and holds it until HREADY.
- **Constant outputs:** `HBURST=3'b000`, `HMASTLOCK=0`, `HPROT=4'b0011`, `HWRITE=1`.
- **HTRANS:** `2'b10` (NONSEQ) in `ADDR`, `2'b00` (IDLE) otherwise; no SEQ transfers. `HADDR = {acc_addr, offset}`.

## Timing
- **Reset values:** all outputs 0, except `HPROT=4'b0011`. FIFO empty, `mask=0`, FSM in `IDLE`.
- **Reset mid-transfer:** abandons the transfer; contents are lost.
- **Full-word latency:** fourth `write_enable` in cycle c → accumulator full at c+1 → FIFO entry at c+2 → `HTRANS=NONSEQ` in cycle c+2 → `HWDATA` valid in c+3.
- **Wait states:** address and data phases stall while `HREADY=0`. All master outputs are held stable.
- **Back-to-back transfers:** the next NONSEQ overlaps the previous data phase. Throughput is one transfer per cycle with zero wait states.
- **Timeout:** the idle counter increments each cycle without `write_enable` while `mask!=0`. The push occurs on the cycle it equals `TIMEOUT_CYCLES`.
- **Simultaneous push and pop on a full FIFO:** the push succeeds; no overflow.
- **`busy` fall:** `busy` falls the cycle after the final data phase completes with HREADY.

## Structure
- **Shared package / `mfp_ahb_lite.vh`:** HTRANS codes (IDLE, NONSEQ), HSIZE codes (8/16/32), HPROT default.
- **Sub-module `mfp_sync_fifo`:** parametrised width and depth, with full, empty and simultaneous push/pop.
- **In this block:** accumulator, mask splitter and issuer FSM.

## Test plan
- **Word coalescing, little-endian:** bytes 11,22,33,44 written to 0x100..0x103 → one write, `HADDR=0x100`, `HSIZE=2`, `HWDATA=0x44332211`.
- **Word coalescing, big-endian:** the same stimulus → `HWDATA=0x11223344`.
- **Split on flush:** bytes to 0x200, 0x201, 0x203, then `flush` → halfword @0x200 followed by byte @0x203, back-to-back.
- **Timeout:** byte 0xAA to 0x305, then idle for `TIMEOUT_CYCLES` → byte write @0x305 with `HWDATA[15:8]=0xAA`.
- **Wait states:** `HREADY` low for 3 cycles during a data phase → HADDR, HTRANS and HWDATA stable; no transfers lost; `busy` clears afterwards.
- **Overflow:** `HREADY=0`, `FIFO_DEPTH+2` distinct-word full pushes → `overflow=1`; exactly `FIFO_DEPTH+1` writes issued after HREADY returns.
